// File: rtl/led_mmio_pkg.sv
// Shared definitions for the LED MMIO controller.
//   - Page addresses (daddr[31:16]) of the three mapped registers.
//   - Bit positions of the control/status fields in the 32-bit data word.
//   - Prescaler FSM state type and the register-select decode helper.
package led_mmio_pkg;

    localparam logic [15:0] LED_R_ADDR      = 16'h8000;
    localparam logic [15:0] LED_G_ADDR      = 16'h8004;
    localparam logic [15:0] LED_PERIOD_ADDR = 16'h8008;

    localparam int ON_BIT    = 24;
    localparam int BLINK_BIT = 25;
    localparam int PHASE_BIT = 26;

    typedef enum logic {
        IDLE,
        RUN
    } blink_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_R,
        SEL_G,
        SEL_PERIOD
    } reg_sel_t;

    // Only the upper half of the address selects a register; the low half
    // is a don't-care so any offset inside a page aliases the register.
    function automatic reg_sel_t decode_page(input logic [15:0] page);
        reg_sel_t sel;
        case (page)
            LED_R_ADDR:      sel = SEL_R;
            LED_G_ADDR:      sel = SEL_G;
            LED_PERIOD_ADDR: sel = SEL_PERIOD;
            default:         sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_blink_prescaler.sv
// Shared half-period prescaler for the blinking LEDs.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   period           : half-period in cycles (0 behaves as 1)
//   restart          : force cnt = 0, phase = 1 this edge (PERIOD write)
//   run_req          : any LED has blink enabled
//   phase            : current blink phase, 1 while idle
module led_blink_prescaler
    import led_mmio_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [CNT_W-1:0] period,
    input  logic             restart,
    input  logic             run_req,
    output logic             phase
);

    blink_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             tick;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        // Terminal count is max(period,1)-1, so period 0 ticks every cycle.
        last      = (period == '0) ? '0 : period - CNT_W'(1);
        tick      = (state == RUN) && (cnt == last);
        case (state)
            IDLE:    if (run_req)  state_nxt = RUN;
            RUN:     if (!run_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Restart takes priority over a coincident tick.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart || state == IDLE) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped red/green status LED controller on the CPU data port.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   we, re           : CPU store / load strobes
//   daddr, din       : CPU data address / store data
//   mmio_hit         : combinational window hit (top masks DRAM write)
//   ack, dout        : one-cycle registered ack with registered read data
//   led_r, led_g     : registered LED drives
// Optional: define LED_PWM_EN to add a 4-bit duty field at ctrl[31:28]
// that dims the solid-on output with a free-running 4-bit PWM counter.
module led_mmio_ctrl
    import led_mmio_pkg::*;
#(
    parameter int CNT_W               = 26,
    parameter int DEFAULT_HALF_PERIOD = 25_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic        mmio_hit,
    output logic        ack,
    output logic [31:0] dout,
    output logic        led_r,
    output logic        led_g
);

    reg_sel_t         sel;
    logic             r_on, r_blink, g_on, g_blink;
    logic [CNT_W-1:0] period;
    logic             phase;
    logic             restart;
    logic             solid_r, solid_g;
    logic [31:0]      rdata;

    assign sel      = decode_page(daddr[31:16]);
    assign mmio_hit = (sel != SEL_NONE);
    assign restart  = we && (sel == SEL_PERIOD);

`ifdef LED_PWM_EN
    logic [3:0] r_duty, g_duty, pwm_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) pwm_cnt <= '0;
        else         pwm_cnt <= pwm_cnt + 4'd1;
    end

    // Duty 0xF is full-on rather than 15/16.
    assign solid_r = r_on && ((r_duty == 4'hF) || (pwm_cnt < r_duty));
    assign solid_g = g_on && ((g_duty == 4'hF) || (pwm_cnt < g_duty));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_duty <= 4'hF;
            g_duty <= 4'hF;
        end else if (we) begin
            if (sel == SEL_R) r_duty <= din[31:28];
            if (sel == SEL_G) g_duty <= din[31:28];
        end
    end
`else
    assign solid_r = r_on;
    assign solid_g = g_on;
`endif

    // Control and period registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_on    <= 1'b0;
            r_blink <= 1'b0;
            g_on    <= 1'b0;
            g_blink <= 1'b0;
            period  <= CNT_W'(DEFAULT_HALF_PERIOD);
        end else if (we) begin
            case (sel)
                SEL_R: begin
                    r_on    <= din[ON_BIT];
                    r_blink <= din[BLINK_BIT];
                end
                SEL_G: begin
                    g_on    <= din[ON_BIT];
                    g_blink <= din[BLINK_BIT];
                end
                SEL_PERIOD: period <= din[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Read mux uses pre-write register values so a combined we+re returns
    // the old contents.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_R: begin
                rdata[ON_BIT]    = r_on;
                rdata[BLINK_BIT] = r_blink;
                rdata[PHASE_BIT] = phase;
`ifdef LED_PWM_EN
                rdata[31:28]     = r_duty;
`endif
            end
            SEL_G: begin
                rdata[ON_BIT]    = g_on;
                rdata[BLINK_BIT] = g_blink;
                rdata[PHASE_BIT] = phase;
`ifdef LED_PWM_EN
                rdata[31:28]     = g_duty;
`endif
            end
            SEL_PERIOD: rdata = 32'(period);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack   <= 1'b0;
            dout  <= '0;
            led_r <= 1'b0;
            led_g <= 1'b0;
        end else begin
            ack   <= (we || re) && mmio_hit;
            dout  <= ((we || re) && mmio_hit) ? rdata : '0;
            led_r <= r_blink ? phase : solid_r;
            led_g <= g_blink ? phase : solid_g;
        end
    end

    led_blink_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .period  (period),
        .restart (restart),
        .run_req (r_blink || g_blink),
        .phase   (phase)
    );

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// Randomized scoreboard bench for led_mmio_ctrl (default build, no PWM).
// The reference model tracks the blink phase as the number of counting
// cycles since the last restart divided by the half-period.
module tb_led_mmio_ctrl;

    localparam int CNT_W = 26;
    localparam int DEF_P = 25_000_000;

    logic        sys_clk = 1'b0;
    logic        sys_rst, we, re;
    logic [31:0] daddr, din;
    logic        mmio_hit, ack, led_r, led_g;
    logic [31:0] dout;

    always #5 sys_clk = ~sys_clk;

    led_mmio_ctrl #(
        .CNT_W               (CNT_W),
        .DEFAULT_HALF_PERIOD (DEF_P)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .we       (we),
        .re       (re),
        .daddr    (daddr),
        .din      (din),
        .mmio_hit (mmio_hit),
        .ack      (ack),
        .dout     (dout),
        .led_r    (led_r),
        .led_g    (led_g)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // 0 none, 1 red, 2 green, 3 period
    function automatic int page_sel(input logic [31:0] a);
        case (a[31:16])
            16'h8000: return 1;
            16'h8004: return 2;
            16'h8008: return 3;
            default:  return 0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    bit          m_r_on, m_r_blink, m_g_on, m_g_blink;
    int unsigned m_period;
    longint      m_run_cycles;   // counting cycles since last restart/idle
    bit          m_running;
    bit          m_led_r, m_led_g;
    logic [31:0] exp_q[$];

    function automatic bit m_phase();
        longint per;
        per = (m_period == 0) ? 1 : m_period;
        return ((m_run_cycles / per) % 2) == 0;
    endfunction

    always @(posedge sys_clk) begin : model
        int          sel;
        bit          ph;
        logic [31:0] rd;
        sel = page_sel(daddr);
        ph  = m_phase();
        if (sys_rst) begin
            m_r_on <= 0; m_r_blink <= 0; m_g_on <= 0; m_g_blink <= 0;
            m_period <= DEF_P; m_run_cycles <= 0; m_running <= 0;
            m_led_r <= 0; m_led_g <= 0;
        end else begin
            if (sel != 0 && (we || re)) begin
                rd = '0;
                case (sel)
                    1: begin rd[26] = ph; rd[25] = m_r_blink; rd[24] = m_r_on; end
                    2: begin rd[26] = ph; rd[25] = m_g_blink; rd[24] = m_g_on; end
                    default: rd = m_period;
                endcase
                exp_q.push_back(rd);
            end
            m_led_r <= m_r_blink ? ph : m_r_on;
            m_led_g <= m_g_blink ? ph : m_g_on;
            if ((we && sel == 3) || !m_running) m_run_cycles <= 0;
            else                                m_run_cycles <= m_run_cycles + 1;
            m_running <= m_r_blink || m_g_blink;
            if (we) begin
                case (sel)
                    1: begin m_r_on <= din[24]; m_r_blink <= din[25]; end
                    2: begin m_g_on <= din[24]; m_g_blink <= din[25]; end
                    3: m_period <= din[25:0];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin : monitor
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ack", ack, 1);
            check("dout", dout, e);
        end else begin
            check("ack_idle", ack, 0);
            check("dout_idle", dout, 0);
        end
        check("led_r", led_r, m_led_r);
        check("led_g", led_g, m_led_g);
    end

    // ---------------- stimulus ----------------
    task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        we = w; re = r; daddr = a; din = d;
        #1 check("mmio_hit", mmio_hit, page_sel(a) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            we = 0; re = 0; daddr = '0; din = '0;
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int          k, op;
        sys_rst = 1; we = 0; re = 0; daddr = '0; din = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 0;
        idle(2);

        // reset value of PERIOD, then solid red on, then unmapped write
        access(0, 1, 32'h8008_0000, 32'h0);
        access(1, 0, 32'h8000_0000, 32'h0100_0000);
        access(1, 0, 32'h1000_0000, 32'hFFFF_FFFF);
        idle(3);

        // green blinking with half-period 4
        access(1, 0, 32'h8008_0000, 32'd4);
        access(1, 0, 32'h8004_0000, 32'h0200_0000);
        idle(20);
        for (int i = 0; i < 6; i++) begin
            access(0, 1, 32'h8004_1234, 32'h0);
            idle(1);
        end

        // period 0: toggle every cycle; rewrite coincides with a tick
        access(1, 0, 32'h8008_0000, 32'd0);
        idle(5);
        access(1, 0, 32'h8008_0000, 32'd0);
        access(0, 1, 32'h8004_0000, 32'h0);
        idle(3);
        access(1, 0, 32'h8008_0000, 32'd3);
        idle(9);

        // combined we+re returns old value and clears red
        access(1, 1, 32'h8000_0000, 32'h0);
        idle(3);

        // randomized traffic with short periods
        for (int i = 0; i < 400; i++) begin
            k  = $urandom_range(0, 9);
            op = $urandom_range(0, 3);
            d  = $urandom;
            case (k)
                0, 1, 2: a = {16'h8000, 16'($urandom)};
                3, 4, 5: a = {16'h8004, 16'($urandom)};
                6: begin
                    a = {16'h8008, 16'($urandom)};
                    d = (d & 32'hFC00_0000) | $urandom_range(0, 5);
                end
                default: begin
                    a = $urandom;
                    if (page_sel(a) != 0) a[31] = 1'b0;
                end
            endcase
            if (op == 0) idle(1);
            else access(op[0], op[1], a, d);
        end
        idle(2);

        // reset while blinking with an access pending in the same cycle
        access(1, 0, 32'h8008_0000, 32'd3);
        access(1, 0, 32'h8000_0000, 32'h0200_0000);
        access(1, 0, 32'h8004_0000, 32'h0300_0000);
        idle(7);
        @(negedge sys_clk);
        sys_rst = 1; we = 1; re = 1; daddr = 32'h8000_0000; din = 32'h0100_0000;
        @(negedge sys_clk);
        check("rst_ack", ack, 0);
        check("rst_dout", dout, 0);
        check("rst_led", {led_r, led_g}, 0);
        sys_rst = 0; we = 0; re = 0; daddr = '0; din = '0;
        idle(4);
        access(0, 1, 32'h8008_0000, 32'h0);
        access(0, 1, 32'h8000_0000, 32'h0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_mmio_ctrl.md
Name: led_mmio_ctrl

Overview:
- Memory-mapped controller for the board's red/green status LEDs, attached to the CPU data-memory port alongside DRAM.
- Decodes the 0x800x_xxxx peripheral window and tells the top level to mask DRAM writes on a hit.
- Holds per-LED control registers and sequences solid or blinking output from a shared half-period prescaler.
- Acks every mapped access one cycle later, with registered read data.

Parameters:
- CNT_W, 26, width of the prescaler counter and the PERIOD register.
- DEFAULT_HALF_PERIOD, 25_000_000, reset value of PERIOD in sys_clk cycles (0.5 s at 50 MHz).

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- we  in  1  CPU store strobe.
- re  in  1  CPU load strobe.
- daddr  in  32  CPU data address.
- din  in  32  CPU store data.
- mmio_hit  out  1  combinational; high when daddr is in the mapped window. The top level uses it to clear the DRAM write enable.
- ack  out  1  registered; high for one cycle after a mapped access.
- dout  out  32  registered read data, valid while ack is high.
- led_r  out  1  red LED drive.
- led_g  out  1  green LED drive.

Behaviour:
- Decode on daddr[31:16] only (low half ignored):
  - 0x8000 → R_CTRL
  - 0x8004 → G_CTRL
  - 0x8008 → PERIOD
  - mmio_hit = 1 for exactly these three values, else 0.
- Register formats:
  - R_CTRL and G_CTRL: bit24 = on, bit25 = blink_en.
  - PERIOD: bits[CNT_W-1:0] = half-period.
- Writes:
  - When we & mmio_hit, the addressed register updates at the next edge; unused din bits are ignored.
  - Write-data bit 24 of R_CTRL/G_CTRL stays the solid on/off bit.
- Reads:
  - When (re | we) & mmio_hit, ack = 1 on the following cycle.
  - dout shows the register's value before any same-cycle write: ctrl bits at [25:24], current phase at bit 26, PERIOD zero-extended.
  - ack = 0 and dout = 0 otherwise.
  - Simultaneous we and re count as one access with one ack.
- Prescaler FSM, states IDLE and RUN:
  - IDLE: cnt held at 0, phase = 1.
  - IDLE → RUN when either blink_en = 1.
  - RUN → IDLE when both blink_en = 0.
  - In RUN, cnt increments each cycle. When cnt == max(PERIOD,1)-1: tick, cnt wraps to 0, phase toggles.
  - PERIOD = 0 behaves as 1, so phase toggles every cycle.
- Restarts:
  - A write to PERIOD forces cnt = 0 and phase = 1 at that edge; the write wins over a coincident tick.
  - Setting blink_en on an LED does not restart the shared phase.
- LED output: led_x = blink_en_x ? phase : on_x, registered (one cycle after the register or phase change).
- Reset values:
  - All ctrl registers 0, PERIOD = DEFAULT_HALF_PERIOD.
  - cnt = 0, phase = 1, state IDLE.
  - ack = 0, dout = 0, led_r = led_g = 0.
- Reset mid-access discards the pending ack.

Optional Feature:
- Macro LED_PWM_EN.
- When defined:
  - R_CTRL/G_CTRL bits[31:28] hold a 4-bit duty. A free-running 4-bit pwm counter runs.
  - The solid-on output becomes on_x & (pwm_cnt < duty_x); duty 0xF counts as full-on (16/16).
  - Duty resets to 0xF and is readable at dout[31:28].
- When undefined: bits[31:28] are ignored and read as 0, and solid-on is constant 1.

Decomposition:
- Package led_mmio_pkg holds:
  - address constants LED_R_ADDR = 16'h8000, LED_G_ADDR = 16'h8004, LED_PERIOD_ADDR = 16'h8008;
  - bit-position constants ON_BIT = 24, BLINK_BIT = 25, PHASE_BIT = 26;
  - enum blink_state_t {IDLE, RUN}.
- One sub-module, led_blink_prescaler: cnt, phase and FSM, with inputs period, restart, run_req.

Test Plan:
- Reset, then read 0x80080000 → ack after 1 cycle, dout = 25_000_000; led_r = led_g = 0.
- Write 0x01000000 to 0x80000000 → mmio_hit = 1 that cycle, led_r = 1 one cycle later, led_g = 0; write to 0x10000000 → mmio_hit = 0, no ack.
- Write PERIOD = 4, G_CTRL = 0x02000000 → led_g toggles every 4 cycles, starting high; read G_CTRL shows bit25 = 1 and bit26 tracking phase.
- Write PERIOD = 0 while blinking → phase toggles every cycle. A PERIOD write coinciding with a tick → cnt = 0, phase = 1.
- Simultaneous we + re to R_CTRL with din = 0 after on = 1 → single ack, dout bit24 = 1, led_r = 0 afterwards.
- Assert sys_rst during blinking and a pending ack → next cycle all outputs 0, PERIOD back to default, FSM IDLE.
